// File: rtl/datapath_seq.sv
// datapath_seq: register file with A/B/C operand registers, shifter, ALU and
//   {V,N,Z} status register, driven by a built-in IDLE/RDA/RDB/EXE/WB sequencer.
// Ports: clk/rst_n; request handshake req_valid/req_ready with operation fields
//   (rd, rn, rm, alu_op, shift, asel, bsel, wsel, wb_en, set_flags, imm);
//   mdata/pc sampled at writeback; result (C), flags, done pulse; dbg_rnum/dbg_data.
module datapath_seq #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int RW    = $clog2(NREG),
  parameter int PCW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    rn,
  input  logic [RW-1:0]    rm,
  input  logic [1:0]       alu_op,
  input  logic [1:0]       shift,
  input  logic             asel,
  input  logic             bsel,
  input  logic [1:0]       wsel,
  input  logic             wb_en,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] mdata,
  input  logic [PCW-1:0]   pc,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic             done,
  input  logic [RW-1:0]    dbg_rnum,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int M = WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_EXE  = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] rf_q [NREG];
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [2:0]       flags_q;

  // Request fields captured at accept; live inputs are ignored while busy.
  logic [RW-1:0]    rd_q, rn_q, rm_q;
  logic [1:0]       alu_op_q, shift_q, wsel_q;
  logic             asel_q, bsel_q, wb_en_q, set_flags_q;
  logic [WIDTH-1:0] imm_q;

  logic             accept;
  logic [WIDTH-1:0] b_shift, a_op, b_op, alu_out, pc_ext, wb_data;
  logic             alu_v;

  // ---------------------------------------------------------------- sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        // Non-ALU writebacks need no operand fetch and go straight to WB.
        if (req_valid) state_d = (wsel == 2'b00) ? S_RDA : S_WB;
      end
      S_RDA:   state_d = S_RDB;
      S_RDB:   state_d = S_EXE;
      S_EXE:   state_d = S_WB;
      S_WB: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------- shifter / ALU
  always_comb begin
    case (shift_q)
      2'b01:   b_shift = {b_q[M-1:0], 1'b0};
      2'b10:   b_shift = {1'b0, b_q[M:1]};
      2'b11:   b_shift = {b_q[M], b_q[M:1]};
      default: b_shift = b_q;
    endcase
  end

  assign a_op = asel_q ? '0 : a_q;
  assign b_op = bsel_q ? imm_q : b_shift;

  always_comb begin
    alu_out = '0;
    alu_v   = 1'b0;
    case (alu_op_q)
      2'b00: begin
        alu_out = a_op + b_op;
        // Overflow: operands agree in sign, result disagrees.
        alu_v   = (a_op[M] == b_op[M]) && (alu_out[M] != a_op[M]);
      end
      2'b01: begin
        alu_out = a_op - b_op;
        // Overflow: operands differ in sign, result sign differs from A.
        alu_v   = (a_op[M] != b_op[M]) && (alu_out[M] != a_op[M]);
      end
      2'b10:   alu_out = a_op & b_op;
      default: alu_out = ~b_op;
    endcase
  end

  // -------------------------------------------------------- writeback select
  always_comb begin
    pc_ext          = '0;
    pc_ext[PCW-1:0] = pc;
  end

  always_comb begin
    case (wsel_q)
      2'b01:   wb_data = imm_q;
      2'b10:   wb_data = mdata;
      2'b11:   wb_data = pc_ext;
      default: wb_data = c_q;
    endcase
  end

  // ------------------------------------------------------------- datapath regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      flags_q     <= '0;
      rd_q        <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      alu_op_q    <= '0;
      shift_q     <= '0;
      wsel_q      <= '0;
      asel_q      <= 1'b0;
      bsel_q      <= 1'b0;
      wb_en_q     <= 1'b0;
      set_flags_q <= 1'b0;
      imm_q       <= '0;
    end else begin
      if (accept) begin
        rd_q        <= rd;
        rn_q        <= rn;
        rm_q        <= rm;
        alu_op_q    <= alu_op;
        shift_q     <= shift;
        wsel_q      <= wsel;
        asel_q      <= asel;
        bsel_q      <= bsel;
        wb_en_q     <= wb_en;
        set_flags_q <= set_flags;
        imm_q       <= imm;
      end
      if (state_q == S_RDA) a_q <= rf_q[rn_q];
      if (state_q == S_RDB) b_q <= rf_q[rm_q];
      if (state_q == S_EXE) begin
        c_q <= alu_out;
        if (set_flags_q) flags_q <= {alu_v, alu_out[M], (alu_out == '0)};
      end
      if (state_q == S_WB && wb_en_q) rf_q[rd_q] <= wb_data;
    end
  end

  assign result   = c_q;
  assign flags    = flags_q;
  assign dbg_data = rf_q[dbg_rnum];

endmodule

// File: tb/tb_datapath_seq.sv
module tb_datapath_seq;

  typedef struct packed {
    logic [2:0]  rd;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [1:0]  alu_op;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [1:0]  wsel;
    logic        wb_en;
    logic        set_flags;
    logic [15:0] imm;
    logic [15:0] mdata;
    logic [7:0]  pc;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 16-bit / 8-register instance
  logic        req_valid, req_ready;
  logic [2:0]  rd, rn, rm, dbg_rnum;
  logic [1:0]  alu_op, shift, wsel;
  logic        asel, bsel, wb_en, set_flags, done;
  logic [15:0] imm, mdata, result, dbg_data;
  logic [7:0]  pc;
  logic [2:0]  flags;

  // 8-bit / 4-register instance
  logic        p_req_valid, p_req_ready;
  logic [1:0]  p_rd, p_rn, p_rm, p_dbg_rnum;
  logic [1:0]  p_alu_op, p_shift, p_wsel;
  logic        p_asel, p_bsel, p_wb_en, p_set_flags, p_done;
  logic [7:0]  p_imm, p_mdata, p_result, p_dbg_data, p_pc;
  logic [2:0]  p_flags;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_rf [8];
  int         m_c;
  logic [2:0] m_flags;

  datapath_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .rd(rd), .rn(rn), .rm(rm), .alu_op(alu_op), .shift(shift), .asel(asel),
    .bsel(bsel), .wsel(wsel), .wb_en(wb_en), .set_flags(set_flags), .imm(imm),
    .mdata(mdata), .pc(pc), .result(result), .flags(flags), .done(done),
    .dbg_rnum(dbg_rnum), .dbg_data(dbg_data)
  );

  datapath_seq #(.WIDTH(8), .NREG(4), .PCW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(p_req_valid), .req_ready(p_req_ready),
    .rd(p_rd), .rn(p_rn), .rm(p_rm), .alu_op(p_alu_op), .shift(p_shift),
    .asel(p_asel), .bsel(p_bsel), .wsel(p_wsel), .wb_en(p_wb_en),
    .set_flags(p_set_flags), .imm(p_imm), .mdata(p_mdata), .pc(p_pc),
    .result(p_result), .flags(p_flags), .done(p_done),
    .dbg_rnum(p_dbg_rnum), .dbg_data(p_dbg_data)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic req_t mk(input int rd_v, rn_v, rm_v, op_v, sh_v, as_v, bs_v,
                              ws_v, we_v, sf_v, imm_v);
    req_t r;
    r = '0;
    r.rd = 3'(rd_v);   r.rn = 3'(rn_v);     r.rm = 3'(rm_v);
    r.alu_op = 2'(op_v); r.shift = 2'(sh_v);
    r.asel = 1'(as_v); r.bsel = 1'(bs_v);   r.wsel = 2'(ws_v);
    r.wb_en = 1'(we_v); r.set_flags = 1'(sf_v); r.imm = 16'(imm_v);
    return r;
  endfunction

  function automatic int sx(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Behavioural model: whole operation in one step using signed integer arithmetic.
  function automatic void model_exec(input req_t r);
    int a, b, bs, res, full;
    logic v;
    v = 1'b0;
    if (r.wsel == 2'd0) begin
      a = r.asel ? 0 : m_rf[r.rm == r.rm ? r.rn : r.rn];
      case (r.shift)
        2'd0:    bs = m_rf[r.rm];
        2'd1:    bs = (m_rf[r.rm] * 2) % 65536;
        2'd2:    bs = m_rf[r.rm] / 2;
        default: bs = (sx(m_rf[r.rm]) >>> 1) & 32'hFFFF;
      endcase
      b = r.bsel ? int'(r.imm) : bs;
      case (r.alu_op)
        2'd0: begin full = sx(a) + sx(b); v = (full > 32767) || (full < -32768); res = full & 32'hFFFF; end
        2'd1: begin full = sx(a) - sx(b); v = (full > 32767) || (full < -32768); res = full & 32'hFFFF; end
        2'd2: res = a & b;
        default: res = (~b) & 32'hFFFF;
      endcase
      m_c = res;
      if (r.set_flags) m_flags = {v, (res >= 32768), (res == 0)};
    end else begin
      case (r.wsel)
        2'd1:    res = int'(r.imm);
        2'd2:    res = int'(r.mdata);
        default: res = int'(r.pc);
      endcase
    end
    if (r.wb_en) m_rf[r.rd] = res;
  endfunction

  task automatic drive_req(input req_t r);
    rd = r.rd; rn = r.rn; rm = r.rm; alu_op = r.alu_op; shift = r.shift;
    asel = r.asel; bsel = r.bsel; wsel = r.wsel; wb_en = r.wb_en;
    set_flags = r.set_flags; imm = r.imm; mdata = r.mdata; pc = r.pc;
  endtask

  // Called in the low clock phase; returns at the negedge after done (write visible).
  // lat = index of the post-accept cycle in which done was seen, -1 on timeout.
  task automatic run_op(input req_t r, output int lat);
    int g;
    g = 0;
    while (req_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    drive_req(r);
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      if (done === 1'b1) begin lat = n; break; end
      @(negedge clk);
    end
    model_exec(r);
    @(negedge clk);
  endtask

  task automatic run_op8(input req_t r, output int lat);
    int g;
    g = 0;
    while (p_req_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    p_rd = r.rd[1:0]; p_rn = r.rn[1:0]; p_rm = r.rm[1:0]; p_alu_op = r.alu_op;
    p_shift = r.shift; p_asel = r.asel; p_bsel = r.bsel; p_wsel = r.wsel;
    p_wb_en = r.wb_en; p_set_flags = r.set_flags; p_imm = r.imm[7:0];
    p_mdata = r.mdata[7:0]; p_pc = r.pc;
    p_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    p_req_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      if (p_done === 1'b1) begin lat = n; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    req_valid = 0; p_req_valid = 0;
    drive_req('0);
    dbg_rnum = 0; p_dbg_rnum = 0;
    p_rd = 0; p_rn = 0; p_rm = 0; p_alu_op = 0; p_shift = 0; p_asel = 0; p_bsel = 0;
    p_wsel = 0; p_wb_en = 0; p_set_flags = 0; p_imm = 0; p_mdata = 0; p_pc = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
    m_c = 0; m_flags = 3'b000;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (result !== 16'h0) begin bad++; $display("FAIL reset_result: got %h want 0000", result); end
    total++; if (flags !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", flags); end
    for (int i = 0; i < 8; i++) begin
      dbg_rnum = 3'(i); #1;
      total++; if (dbg_data !== 16'h0) begin bad++; $display("FAIL reset_reg%0d: got %h want 0000", i, dbg_data); end
    end
  endtask

  task automatic test_imm_load();
    int lat;
    run_op(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0007), lat);
    dbg_rnum = 3'd1; #1;
    total++; if (lat !== 1) begin bad++; $display("FAIL imm_latency: got %0d want 1", lat); end
    total++; if (dbg_data !== 16'h0007) begin bad++; $display("FAIL imm_r1: got %h want 0007", dbg_data); end
    total++; if (flags !== m_flags) begin bad++; $display("FAIL imm_flags: got %b want %b", flags, m_flags); end
  endtask

  task automatic test_add_overflow();
    int lat;
    run_op(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h7FFF), lat);
    run_op(mk(2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0001), lat);
    run_op(mk(3, 1, 2, 0, 0, 0, 0, 0, 1, 1, 0), lat);
    dbg_rnum = 3'd3; #1;
    total++; if (lat !== 4) begin bad++; $display("FAIL add_latency: got %0d want 4", lat); end
    total++; if (result !== 16'h8000) begin bad++; $display("FAIL add_result: got %h want 8000", result); end
    total++; if (flags !== 3'b110) begin bad++; $display("FAIL add_flags: got %b want 110", flags); end
    total++; if (dbg_data !== 16'h8000) begin bad++; $display("FAIL add_r3: got %h want 8000", dbg_data); end
    // A following non-ALU write must leave C and flags alone.
    run_op(mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0), lat);
    total++; if (flags !== 3'b110) begin bad++; $display("FAIL nonalu_flags: got %b want 110", flags); end
    total++; if (result !== 16'h8000) begin bad++; $display("FAIL nonalu_result: got %h want 8000", result); end
  endtask

  task automatic test_sub_asr();
    int lat;
    run_op(mk(4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0008), lat);
    run_op(mk(5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0010), lat);
    run_op(mk(6, 4, 5, 1, 3, 0, 0, 0, 1, 1, 0), lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL sub_latency: got %0d want 4", lat); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL sub_result: got %h want 0000", result); end
    total++; if (flags !== 3'b001) begin bad++; $display("FAIL sub_flags: got %b want 001", flags); end
  endtask

  task automatic test_back_to_back();
    int lat;
    req_t op1, op2;
    logic [1:0] exp;
    run_op(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3), lat);
    run_op(mk(2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4), lat);
    op1 = mk(6, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0);
    op2 = mk(7, 6, 6, 0, 0, 0, 0, 0, 1, 0, 0);
    drive_req(op1);
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive_req(op2);   // request stays valid while the first op is busy
    for (int n = 1; n <= 5; n++) begin
      exp = (n == 5) ? 2'b10 : {1'b0, (n == 4)};
      total++; if ({req_ready, done} !== exp) begin bad++; $display("FAIL b2b_cycle%0d ready,done: got %b want %b", n, {req_ready, done}, exp); end
      if (n < 5) @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      if (done === 1'b1) begin lat = n; break; end
      @(negedge clk);
    end
    @(negedge clk);
    model_exec(op1);
    model_exec(op2);
    total++; if (lat !== 4) begin bad++; $display("FAIL b2b_latency: got %0d want 4", lat); end
    dbg_rnum = 3'd6; #1;
    total++; if (dbg_data !== 16'(m_rf[6])) begin bad++; $display("FAIL b2b_r6: got %h want %h", dbg_data, 16'(m_rf[6])); end
    dbg_rnum = 3'd7; #1;
    total++; if (dbg_data !== 16'(m_rf[7])) begin bad++; $display("FAIL b2b_r7: got %h want %h", dbg_data, 16'(m_rf[7])); end
  endtask

  task automatic test_random();
    int lat, expl;
    req_t r;
    for (int k = 0; k < 40; k++) begin
      r = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
             ($urandom_range(0, 5) != 0), $urandom_range(0, 1), $urandom_range(0, 65535));
      r.mdata = 16'($urandom_range(0, 65535));
      r.pc    = 8'($urandom_range(0, 255));
      expl = (r.wsel == 2'd0) ? 4 : 1;
      run_op(r, lat);
      dbg_rnum = r.rd; #1;
      total++; if (lat !== expl) begin bad++; $display("FAIL rand%0d_latency: got %0d want %0d", k, lat, expl); end
      total++; if (result !== 16'(m_c)) begin bad++; $display("FAIL rand%0d_result: got %h want %h", k, result, 16'(m_c)); end
      total++; if (flags !== m_flags) begin bad++; $display("FAIL rand%0d_flags: got %b want %b", k, flags, m_flags); end
      total++; if (dbg_data !== 16'(m_rf[r.rd])) begin bad++; $display("FAIL rand%0d_rd: got %h want %h", k, dbg_data, 16'(m_rf[r.rd])); end
    end
    for (int i = 0; i < 8; i++) begin
      dbg_rnum = 3'(i); #1;
      total++; if (dbg_data !== 16'(m_rf[i])) begin bad++; $display("FAIL rand_final_r%0d: got %h want %h", i, dbg_data, 16'(m_rf[i])); end
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    run_op(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5), lat);
    drive_req(mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0));
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);          // RDA
    req_valid = 1'b0;
    @(negedge clk);          // RDB
    @(negedge clk);          // EXE
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
    m_c = 0; m_flags = 3'b000;
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done_in_reset: got %b want 0", done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
    total++; if (result !== 16'h0) begin bad++; $display("FAIL midrst_result: got %h want 0000", result); end
    total++; if (flags !== 3'b000) begin bad++; $display("FAIL midrst_flags: got %b want 000", flags); end
    for (int i = 0; i < 8; i++) begin
      dbg_rnum = 3'(i); #1;
      total++; if (dbg_data !== 16'h0) begin bad++; $display("FAIL midrst_r%0d: got %h want 0000", i, dbg_data); end
    end
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_no_done%0d: got %b want 0", n, done); end
    end
    dbg_rnum = 3'd1; #1;
    total++; if (dbg_data !== 16'h0) begin bad++; $display("FAIL midrst_no_write: got %h want 0000", dbg_data); end
  endtask

  task automatic test_param_sweep();
    int lat;
    @(negedge clk);
    run_op8(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 8'h0F), lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL w8_imm_latency: got %0d want 1", lat); end
    run_op8(mk(2, 0, 1, 3, 0, 0, 0, 0, 1, 1, 0), lat);
    p_dbg_rnum = 2'd2; #1;
    total++; if (lat !== 4) begin bad++; $display("FAIL w8_not_latency: got %0d want 4", lat); end
    total++; if (p_result !== 8'hF0) begin bad++; $display("FAIL w8_not_result: got %h want f0", p_result); end
    total++; if (p_flags !== 3'b010) begin bad++; $display("FAIL w8_not_flags: got %b want 010", p_flags); end
    total++; if (p_dbg_data !== 8'hF0) begin bad++; $display("FAIL w8_not_r2: got %h want f0", p_dbg_data); end
    begin
      req_t r;
      r = mk(3, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
      r.mdata = 16'h00A5;
      run_op8(r, lat);
      p_dbg_rnum = 2'd3; #1;
      total++; if (lat !== 1) begin bad++; $display("FAIL w8_mdata_latency: got %0d want 1", lat); end
      total++; if (p_dbg_data !== 8'hA5) begin bad++; $display("FAIL w8_mdata_r3: got %h want a5", p_dbg_data); end
      total++; if (p_flags !== 3'b010) begin bad++; $display("FAIL w8_mdata_flags: got %b want 010", p_flags); end
      r = mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
      r.pc = 8'h3C;
      run_op8(r, lat);
      p_dbg_rnum = 2'd0; #1;
      total++; if (p_dbg_data !== 8'h3C) begin bad++; $display("FAIL w8_pc_r0: got %h want 3c", p_dbg_data); end
    end
  endtask

  initial begin
    test_reset();
    test_imm_load();
    test_add_overflow();
    test_sub_asr();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
